// File: rtl/sockit_cdc_pkg.sv
// Shared defaults and gray-code helpers for the sockit CDC FIFO family.
// Helpers work on a 32-bit word so any pointer width up to 32 can use them.
package sockit_cdc_pkg;

  localparam int FF_DEFAULT  = 4;
  localparam int DW_DEFAULT  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PTR_MAX_W   = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the xor of its gray bit and all gray bits above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sockit_cdc_fifo_if.sv
// Producer (ffi_*) and consumer (ffo_*) req/grt ports of the sockit CDC FIFO.
// master is the surrounding logic; slave is the FIFO itself.
interface sockit_cdc_fifo_if #(
  parameter int DW = sockit_cdc_pkg::DW_DEFAULT
);

  logic [DW-1:0] ffi_bus;
  logic          ffi_req;
  logic          ffi_grt;
  logic [DW-1:0] ffo_bus;
  logic          ffo_req;
  logic          ffo_grt;

  modport master (
    output ffi_bus, ffi_req, ffo_grt,
    input  ffi_grt, ffo_req, ffo_bus
  );

  modport slave (
    input  ffi_bus, ffi_req, ffo_grt,
    output ffi_grt, ffo_req, ffo_bus
  );

endinterface

// File: rtl/sockit_cdc_sync.sv
// N-stage register chain standing in for a pointer synchronizer.
// Latency N cycles; no flow control, every stage clears on synchronous reset.
module sockit_cdc_sync #(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/sockit_cdc_fifo.sv
// Single-clock gray-pointer FIFO, port-compatible with the dual-clock crossing FIFO;
// SOCKIT_CDC_SYNC_EN adds crossing-like latency 3 (else 1); grt/req depend only on registered state.
module sockit_cdc_fifo
  import sockit_cdc_pkg::*;
#(
  parameter int FF = FF_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  sockit_cdc_fifo_if.slave bus
);

  localparam int            DEPTH   = 2 ** (FF - 1);
  localparam logic [FF-1:0] DEPTH_P = FF'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [FF-1:0] wptr;
  logic [FF-1:0] rptr;
  logic [FF-1:0] wptr_nx;
  logic [FF-1:0] rptr_nx;
  logic [FF-1:0] wptr_rd;   // write pointer as the reader sees it
  logic [FF-1:0] rptr_wr;   // read pointer as the writer sees it
  logic [FF-1:0] wr_occ;
  logic [FF-1:0] rd_occ;
  logic          rst_q;
  logic          wr_en;
  logic          rd_en;
  logic          ffi_grt;
  logic          ffo_req;

  assign wr_en   = bus.ffi_req & ffi_grt;
  assign rd_en   = bus.ffo_grt & ffo_req;
  assign wptr_nx = wptr + FF'(wr_en);
  assign rptr_nx = rptr + FF'(rd_en);

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[FF-2:0]] <= bus.ffi_bus;
    end
  end

`ifdef SOCKIT_CDC_SYNC_EN
  logic [FF-1:0] wgray;
  logic [FF-1:0] rgray;
  logic [FF-1:0] wgray_s;
  logic [FF-1:0] rgray_s;

  // Gray copies track the next pointer value so they change with the binary ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      wgray <= '0;
      rgray <= '0;
    end else begin
      wgray <= FF'(bin2gray(ptr_word_t'(wptr_nx)));
      rgray <= FF'(bin2gray(ptr_word_t'(rptr_nx)));
    end
  end

  sockit_cdc_sync #(
    .N (SYNC_STAGES),
    .W (FF)
  ) u_wptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (wgray),
    .q   (wgray_s)
  );

  sockit_cdc_sync #(
    .N (SYNC_STAGES),
    .W (FF)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rgray),
    .q   (rgray_s)
  );

  assign wptr_rd = FF'(gray2bin(ptr_word_t'(wgray_s)));
  assign rptr_wr = FF'(gray2bin(ptr_word_t'(rgray_s)));
`else
  assign wptr_rd = wptr;
  assign rptr_wr = rptr;
`endif

  // Stale views only ever overstate (writer) or understate (reader) occupancy.
  always_comb begin
    wr_occ  = wptr - rptr_wr;
    rd_occ  = wptr_rd - rptr;
    ffi_grt = !rst && !rst_q && (wr_occ < DEPTH_P);
    ffo_req = !rst && !rst_q && (rd_occ != '0);
  end

  assign bus.ffi_grt = ffi_grt;
  assign bus.ffo_req = ffo_req;
  assign bus.ffo_bus = ffo_req ? mem[rptr[FF-2:0]] : '0;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    (wptr - rptr) <= DEPTH_P);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && ((wptr - rptr) == DEPTH_P)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && (wptr == rptr)));

endmodule

// File: tb/tb_sockit_cdc_fifo.sv
// Bench for sockit_cdc_fifo: table-driven fill/drain vectors, scoreboarded random
// traffic, and hand-written latency and mid-stream reset sequences.
module tb_sockit_cdc_fifo;

  localparam int FF    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
`ifdef SOCKIT_CDC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int NVEC = 40;

  typedef struct {
    logic          ffi_req;
    logic [DW-1:0] ffi_bus;
    logic          ffo_grt;
    logic          exp_ffi_grt;
    logic          exp_ffo_req;
    logic [DW-1:0] exp_ffo_bus;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sockit_cdc_fifo_if #(.DW(DW)) bus ();

  sockit_cdc_fifo #(
    .FF (FF),
    .DW (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_chk = 0;
  int            n_err = 0;
  vec_t          vecs [NVEC];
  logic [DW-1:0] sb_q [$];
  int            prod;
  int            cons;
  int            occ;
  int            cyc;
  int            lat;
  bit            found;
  logic          wr;
  logic          rd;
  logic [DW-1:0] exp_word;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event did not occur within its cycle budget", nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ffi_req = 1'b0;
    bus.ffi_bus = '0;
    bus.ffo_grt = 1'b0;

    // Two fill/drain rounds; the second uses fresh data and exercises pointer wrap.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 10; i++) begin
        int k;
        logic [DW-1:0] base;
        k    = p * 10 + i;
        base = (p < 2) ? 8'h00 : 8'h10;
        if (p % 2 == 0) begin
          vecs[k].ffi_req     = 1'b1;
          vecs[k].ffi_bus     = base + 8'(i);
          vecs[k].ffo_grt     = 1'b0;
          vecs[k].exp_ffi_grt = (i < DEPTH);
          vecs[k].exp_ffo_req = (i >= LAT);
          vecs[k].exp_ffo_bus = (i >= LAT) ? base : 8'h00;
        end else begin
          vecs[k].ffi_req     = 1'b0;
          vecs[k].ffi_bus     = 8'hEE;
          vecs[k].ffo_grt     = 1'b1;
          vecs[k].exp_ffi_grt = (i >= LAT);
          vecs[k].exp_ffo_req = (i < DEPTH);
          vecs[k].exp_ffo_bus = (i < DEPTH) ? base + 8'(i) : 8'h00;
        end
      end
    end

    // Reset: outputs quiet for the whole reset, grant one cycle after release.
    repeat (4) begin
      @(negedge clk);
      chk("rst_ffi_grt", bus.ffi_grt, 0);
      chk("rst_ffo_req", bus.ffo_req, 0);
      chk("rst_ffo_bus", bus.ffo_bus, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ffi_grt", bus.ffi_grt, 1);
    chk("rel_ffo_req", bus.ffo_req, 0);

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_ffi_grt", k), bus.ffi_grt, vecs[k].exp_ffi_grt);
      chk($sformatf("vec%0d_ffo_req", k), bus.ffo_req, vecs[k].exp_ffo_req);
      chk($sformatf("vec%0d_ffo_bus", k), bus.ffo_bus, vecs[k].exp_ffo_bus);
      bus.ffi_req = vecs[k].ffi_req;
      bus.ffi_bus = vecs[k].ffi_bus;
      bus.ffo_grt = vecs[k].ffo_grt;
    end

    // Random traffic against the scoreboard.
    prod = 0;
    cons = 0;
    occ  = 0;
    cyc  = 0;
    @(negedge clk);
    bus.ffi_req = 1'b0;
    bus.ffo_grt = 1'b0;
    while (cons < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
`ifndef SOCKIT_CDC_SYNC_EN
      chk("rnd_ffi_grt", bus.ffi_grt, occ < DEPTH);
      chk("rnd_ffo_req", bus.ffo_req, occ != 0);
`endif
      bus.ffi_req = 1'($urandom_range(1, 0));
      bus.ffi_bus = prod[7:0];
      bus.ffo_grt = 1'($urandom_range(1, 0));
      #1;
      wr = bus.ffi_req & bus.ffi_grt;
      rd = bus.ffo_req & bus.ffo_grt;
      if (!bus.ffo_req) chk("rnd_idle_bus", bus.ffo_bus, 0);
      if (rd) begin
        if (sb_q.size() == 0) begin
          fail("rnd_underflow");
        end else begin
          exp_word = sb_q.pop_front();
          chk("rnd_data", bus.ffo_bus, exp_word);
        end
        cons++;
        occ--;
      end
      if (wr) begin
        sb_q.push_back(prod[7:0]);
        prod++;
        occ++;
      end
    end
    chk("rnd_consumed", cons, 64);

    // Drain whatever the random phase left behind.
    @(negedge clk);
    bus.ffi_req = 1'b0;
    bus.ffo_grt = 1'b1;
    repeat (30) begin
      #1;
      if (bus.ffo_req) begin
        if (sb_q.size() == 0) begin
          fail("drain_underflow");
        end else begin
          exp_word = sb_q.pop_front();
          chk("drain_data", bus.ffo_bus, exp_word);
        end
      end
      @(negedge clk);
    end
    chk("drain_sb_empty", sb_q.size(), 0);
    chk("drain_ffo_req", bus.ffo_req, 0);
    chk("drain_ffi_grt", bus.ffi_grt, 1);

    // Latency of a single write into an empty FIFO.
    bus.ffo_grt = 1'b0;
    bus.ffi_req = 1'b1;
    bus.ffi_bus = 8'h3C;
    @(posedge clk);
    #1;
    bus.ffi_req = 1'b0;
    lat   = 0;
    found = 1'b0;
    for (int n = 1; n <= 8 && !found; n++) begin
      @(negedge clk);
      if (bus.ffo_req) begin
        lat   = n;
        found = 1'b1;
      end
    end
    chk("latency", lat, LAT);
    chk("lat_word", bus.ffo_bus, 8'h3C);
    bus.ffo_grt = 1'b1;
    @(negedge clk);
    bus.ffo_grt = 1'b0;
    chk("lat_empty", bus.ffo_req, 0);

    // Reset with five words inside must flush them all.
    for (int i = 0; i < 5; i++) begin
      bus.ffi_req = 1'b1;
      bus.ffi_bus = 8'h50 + 8'(i);
      @(negedge clk);
    end
    bus.ffi_req = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("mid_pre_ffo_req", bus.ffo_req, 1);
    chk("mid_pre_ffo_bus", bus.ffo_bus, 8'h50);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_ffi_grt", bus.ffi_grt, 0);
    chk("mid_rst_ffo_req", bus.ffo_req, 0);
    chk("mid_rst_ffo_bus", bus.ffo_bus, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ffi_grt", bus.ffi_grt, 1);
    repeat (LAT) begin
      chk("mid_rel_ffo_req", bus.ffo_req, 0);
      @(negedge clk);
    end
    bus.ffi_req = 1'b1;
    bus.ffi_bus = 8'hA5;
    @(negedge clk);
    bus.ffi_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      if (bus.ffo_req) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      fail("mid_a5_wait");
    end else begin
      chk("mid_first_word", bus.ffo_bus, 8'hA5);
      bus.ffo_grt = 1'b1;
      @(negedge clk);
      bus.ffo_grt = 1'b0;
      chk("mid_after_read", bus.ffo_req, 0);
      chk("mid_after_bus", bus.ffo_bus, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
